memory_handler: RTL and testbench

//  Multi-cycle load/store unit between the ALU and the register file write port. Takes one
//  RV32I load/store per start pulse and drives a word-aligned data bus with byte enables.

---
 rtl/memory_handler.sv | 159 +++++++++++++++
 tb/tb_memory_handler.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/memory_handler.sv
// Multi-cycle RV32I load/store unit: drives a word bus with byte enables
// and returns extended load data as a one-cycle register file write.
// Ports: clk/nRst; start, mem_read, mem_write, funct3, addr, store_data, rd
// request; bus_req/we/addr/sel/wdata, bus_ack/rdata bus side; reg_write,
// write_index, write_data writeback; busy, access_fault, bus_error status.
module memory_handler #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        start,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_wdata,
  output logic        reg_write,
  output logic [4:0]  write_index,
  output logic [31:0] write_data,
  output logic        busy,
  output logic        access_fault,
  output logic        bus_error
);

  localparam int CW = $clog2(TIMEOUT);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          load_q, we_q;
  logic [31:0]   addr_q, wdata_q, wbd_q;
  logic [1:0]    lo_q;
  logic [2:0]    f3_q;
  logic [4:0]    rd_q;
  logic [3:0]    sel_q;
  logic          fault_q, berr_q;

  logic          req_v, illegal, misal, fault;
  logic          accept, to_hit;
  logic [3:0]    sel_n;
  logic [31:0]   wd_n, sh, ext;

  assign req_v   = mem_read | mem_write;
  assign illegal = (mem_read & mem_write)
                 | (mem_read & ((funct3 == 3'd3) | (funct3[2:1] == 2'b11)))
                 | (mem_write & (funct3 > 3'd2));
  assign misal   = ((funct3[1:0] == 2'b01) & addr[0])
                 | ((funct3 == 3'd2) & (|addr[1:0]));
  assign fault   = illegal | misal;
  assign to_hit  = (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    sel_n = 4'hF;
    wd_n  = store_data;
    unique case (1'b1)
      funct3[1:0] == 2'b00: begin
        sel_n = 4'b0001 << addr[1:0];
        wd_n  = {4{store_data[7:0]}};
      end
      funct3[1:0] == 2'b01: begin
        sel_n = addr[1] ? 4'b1100 : 4'b0011;
        wd_n  = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: if (start & req_v & ~fault) begin
        state_d = S_WAIT;
        cnt_d   = '0;
        accept  = 1'b1;
      end
      S_WAIT: begin
        if (bus_ack)     state_d = S_DONE;
        else if (to_hit) state_d = S_IDLE;
        else             cnt_d   = cnt_q + 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Lane select: byte/half shifted down to bit 0, then extended.
  assign sh = bus_rdata >> {lo_q, 3'b000};

  always_comb begin
    case (f3_q)
      3'd0:    ext = {{24{sh[7]}}, sh[7:0]};
      3'd1:    ext = {{16{sh[15]}}, sh[15:0]};
      3'd4:    ext = {24'h0, sh[7:0]};
      3'd5:    ext = {16'h0, sh[15:0]};
      default: ext = bus_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      load_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      lo_q    <= '0;
      f3_q    <= '0;
      rd_q    <= '0;
      sel_q   <= '0;
      wdata_q <= '0;
      wbd_q   <= '0;
      fault_q <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= (state_q == S_IDLE) & start & req_v & fault;
      berr_q  <= (state_q == S_WAIT) & ~bus_ack & to_hit;
      if (accept) begin
        load_q  <= mem_read;
        we_q    <= mem_write;
        addr_q  <= {addr[31:2], 2'b00};
        lo_q    <= addr[1:0];
        f3_q    <= funct3;
        rd_q    <= rd;
        sel_q   <= sel_n;
        wdata_q <= mem_write ? wd_n : 32'h0;
      end
      if ((state_q == S_WAIT) & bus_ack & load_q)
        wbd_q <= ext;
    end
  end

  assign bus_req      = (state_q == S_WAIT);
  assign busy         = (state_q != S_IDLE);
  assign bus_we       = we_q;
  assign bus_addr     = addr_q;
  assign bus_sel      = sel_q;
  assign bus_wdata    = wdata_q;
  assign reg_write    = (state_q == S_DONE) & load_q & (rd_q != 5'd0);
  assign write_index  = rd_q;
  assign write_data   = wbd_q;
  assign access_fault = fault_q;
  assign bus_error    = berr_q;

endmodule

// File: tb/tb_memory_handler.sv
// Randomized bench for memory_handler against a behavioural model of the
// load/store rules, plus directed access sequences and reset cases.
module tb_memory_handler;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        nRst;
  logic        start, mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic [4:0]  rd;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_sel;
  logic [31:0] bus_wdata;
  logic        reg_write;
  logic [4:0]  write_index;
  logic [31:0] write_data;
  logic        busy, access_fault, bus_error;

  int total = 0;
  int bad   = 0;

  memory_handler #(.TIMEOUT(TO)) dut (
    .clk(clk), .nRst(nRst), .start(start),
    .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .store_data(store_data), .rd(rd),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_sel(bus_sel), .bus_wdata(bus_wdata),
    .reg_write(reg_write), .write_index(write_index),
    .write_data(write_data), .busy(busy),
    .access_fault(access_fault), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic scramble();
    mem_read   = 1'($urandom);
    mem_write  = 1'($urandom);
    funct3     = 3'($urandom);
    addr       = $urandom;
    store_data = $urandom;
    rd         = 5'($urandom);
  endtask

  // ackw: WAIT cycle (1-based) carrying bus_ack; 0 means never acked.
  task automatic run(input bit mr, input bit mw, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] sd,
                     input logic [4:0] r, input int ackw,
                     input logic [31:0] rdata);
    bit          flt, acked;
    logic [31:0] esel, ewd, eres, lane;
    flt = (mr && mw) || (mr && (f3 == 3 || f3 == 6 || f3 == 7))
       || (mw && f3 > 2) || ((f3 == 1 || f3 == 5) && a[0])
       || (f3 == 2 && a % 4 != 0);
    if (f3 % 4 == 0) begin
      esel = 32'(1 << (a % 4));
      ewd  = (sd & 32'hFF) * 32'h0101_0101;
      lane = (rdata >> (8 * (a % 4))) & 32'hFF;
      eres = (f3 == 0 && lane >= 128) ? lane - 256 : lane;
    end else if (f3 % 4 == 1) begin
      esel = ((a / 2) % 2 == 1) ? 32'hC : 32'h3;
      ewd  = (sd & 32'hFFFF) * 32'h0001_0001;
      lane = (rdata >> (16 * ((a / 2) % 2))) & 32'hFFFF;
      eres = (f3 == 1 && lane >= 32768) ? lane - 65536 : lane;
    end else begin
      esel = 32'hF;
      ewd  = sd;
      eres = rdata;
    end
    if (!mw) ewd = 0;

    @(posedge clk); #1;
    start = 1'b1; mem_read = mr; mem_write = mw;
    funct3 = f3; addr = a; store_data = sd; rd = r;
    @(posedge clk); #1;
    start = 1'b0;
    scramble();
    if (!(mr || mw)) begin
      chk("idle_busy", 32'(busy), 0);
      chk("idle_fault", 32'(access_fault), 0);
      return;
    end
    if (flt) begin
      chk("flt_pulse", 32'(access_fault), 1);
      chk("flt_busy", 32'(busy), 0);
      chk("flt_req", 32'(bus_req), 0);
      @(posedge clk); #1;
      chk("flt_clear", 32'(access_fault), 0);
      chk("flt_busy2", 32'(busy), 0);
      return;
    end
    acked = 0;
    for (int j = 1; j <= TO; j++) begin
      chk("w_req", 32'(bus_req), 1);
      chk("w_busy", 32'(busy), 1);
      chk("w_addr", bus_addr, a & 32'hFFFF_FFFC);
      chk("w_we", 32'(bus_we), 32'(mw));
      chk("w_sel", 32'(bus_sel), esel);
      chk("w_wdata", bus_wdata, ewd);
      chk("w_berr", 32'(bus_error), 0);
      bus_ack   = (j == ackw);
      bus_rdata = (j == ackw) ? rdata : $urandom;
      start     = 1'($urandom);
      @(posedge clk); #1;
      bus_ack   = 1'b0;
      start     = 1'b0;
      scramble();
      if (j == ackw) begin
        acked = 1;
        break;
      end
    end
    if (acked) begin
      chk("d_busy", 32'(busy), 1);
      chk("d_req", 32'(bus_req), 0);
      chk("d_rw", 32'(reg_write), 32'(mr && r != 0));
      chk("d_berr", 32'(bus_error), 0);
      if (mr) begin
        chk("d_idx", 32'(write_index), 32'(r));
        chk("d_data", write_data, eres);
      end
      start     = 1'($urandom);
      bus_ack   = 1'($urandom);
      bus_rdata = $urandom;
      @(posedge clk); #1;
      start   = 1'b0;
      bus_ack = 1'b0;
      chk("e_busy", 32'(busy), 0);
      chk("e_rw", 32'(reg_write), 0);
    end else begin
      chk("t_berr", 32'(bus_error), 1);
      chk("t_busy", 32'(busy), 0);
      chk("t_req", 32'(bus_req), 0);
      chk("t_rw", 32'(reg_write), 0);
      @(posedge clk); #1;
      chk("t_clear", 32'(bus_error), 0);
    end
  endtask

  initial begin
    int aw;
    nRst = 1'b0; start = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    funct3 = '0; addr = '0; store_data = '0; rd = '0;
    bus_ack = 1'b0; bus_rdata = '0;
    #12;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_req", 32'(bus_req), 0);
    chk("rst_rw", 32'(reg_write), 0);
    chk("rst_sel", 32'(bus_sel), 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_flags", 32'({access_fault, bus_error}), 0);
    @(negedge clk); nRst = 1'b1;

    run(1, 0, 3'd0, 32'h1003, 32'h0, 5'd5, 1, 32'h80FF_FF7F);
    run(1, 0, 3'd5, 32'h2002, 32'h0, 5'd7, 4, 32'hBEEF_1234);
    run(0, 1, 3'd0, 32'h10, 32'hAB, 5'd3, 1, 32'h0);
    run(1, 0, 3'd2, 32'h6, 32'h0, 5'd1, 1, 32'h0);
    run(1, 0, 3'd2, 32'h40, 32'h0, 5'd9, 0, 32'h0);
    run(1, 0, 3'd2, 32'h44, 32'h0, 5'd9, 2, 32'h1234_5678);
    run(1, 0, 3'd2, 32'h48, 32'h0, 5'd0, 1, 32'hFFFF_FFFF);
    run(1, 0, 3'd1, 32'h22, 32'h0, 5'd4, TO, 32'h8001_7FFF);
    run(0, 1, 3'd1, 32'h32, 32'hCAFE_F00D, 5'd4, 3, 32'h0);
    run(1, 1, 3'd2, 32'h50, 32'h0, 5'd2, 1, 32'h0);
    run(0, 1, 3'd4, 32'h50, 32'h0, 5'd2, 1, 32'h0);
    run(0, 0, 3'd2, 32'h50, 32'h0, 5'd2, 1, 32'h0);

    // Reset while waiting for the bus drops the access at once.
    @(posedge clk); #1;
    start = 1'b1; mem_read = 1'b1; mem_write = 1'b0;
    funct3 = 3'd2; addr = 32'h100; rd = 5'd6;
    @(posedge clk); #1;
    start = 1'b0;
    chk("mr_busy", 32'(busy), 1);
    @(negedge clk); nRst = 1'b0; #1;
    chk("mr_req", 32'(bus_req), 0);
    chk("mr_busy0", 32'(busy), 0);
    @(negedge clk); nRst = 1'b1;
    run(1, 0, 3'd4, 32'h101, 32'h0, 5'd6, 1, 32'h0000_9900);

    for (int i = 0; i < 80; i++) begin
      aw = ($urandom_range(0, 9) == 0) ? 0
         : $urandom_range(1, ($urandom_range(0, 1) == 1) ? 3 : TO);
      run(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
          3'($urandom), $urandom, $urandom, 5'($urandom), aw, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
